operand_streamer: RTL and testbench

Feeds one N×N matrix pair into the sum-stationary systolic array's operand port. It accepts A and B row-major over a simple load handshake, buffers both, then streams column k of A and row k of B per beat, for k = 0..N-1. It raises `last` on the final beat. It sits directly in front of the array, acting as the transmitter for its a/b valid/ready/last receiver.

---
 rtl/mm_pkg.sv | 14 +
 rtl/operand_buffer.sv | 41 ++++
 rtl/operand_streamer.sv | 124 ++++++++++++
 tb/tb_operand_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Types shared by the operand streamer, the systolic array and the result collector.
package mm_pkg;

  localparam int unsigned MM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    STREAM
  } stream_state_t;

  typedef logic [MM_DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/operand_buffer.sv
// N x N operand register file: one row write per cycle, one combinational read port
// that returns either row idx or column idx depending on READ_COLUMN.
module operand_buffer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned N           = 4,
  parameter int unsigned IDX_BITS    = $clog2(N),
  parameter bit          READ_COLUMN = 1'b0
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [IDX_BITS-1:0]            wr_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic [IDX_BITS-1:0]            rd_idx,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_data
);

  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mem;

  // Contents are deliberately not reset; every pair rewrites all N rows before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  generate
    if (READ_COLUMN) begin : g_col
      always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
          rd_data[i] = mem[i][rd_idx];
        end
      end
    end else begin : g_row
      always_comb begin
        rd_data = mem[rd_idx];
      end
    end
  endgenerate

endmodule

// File: rtl/operand_streamer.sv
// Buffers one A/B matrix pair loaded row-major, then streams column k of A and
// row k of B per beat into the systolic array, flagging the final beat with last.
module operand_streamer
  import mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4,
  parameter int unsigned IDX_BITS   = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0] load_data,
  output logic                         a_input_valid,
  output logic                         b_input_valid,
  input  logic                         input_ready,
  output logic                         last,
  output logic [N-1:0][DATA_WIDTH-1:0] a_data,
  output logic [N-1:0][DATA_WIDTH-1:0] b_data,
  output logic                         busy
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);

  stream_state_t                 state;
  logic [IDX_BITS-1:0]           row_idx;
  logic [IDX_BITS-1:0]           beat_idx;
  logic                          load_fire;
  logic                          xfer;
  logic                          streaming;
  logic [N-1:0][DATA_WIDTH-1:0]  a_col;
  logic [N-1:0][DATA_WIDTH-1:0]  b_row;

  // Valids and last come only from registered state and beat_idx, never from input_ready.
  assign streaming     = (state == STREAM);
  assign load_ready    = !streaming;
  assign a_input_valid = streaming;
  assign b_input_valid = streaming;
  assign last          = streaming && (beat_idx == LAST_IDX);
  assign a_data        = streaming ? a_col : '0;
  assign b_data        = streaming ? b_row : '0;
  assign busy          = !((state == LOAD_A) && (row_idx == '0));

  assign load_fire = load_valid && load_ready;
  assign xfer      = a_input_valid && b_input_valid && input_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LOAD_A;
      row_idx  <= '0;
      beat_idx <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (load_fire) begin
            if (row_idx == LAST_IDX) begin
              row_idx <= '0;
              state   <= LOAD_B;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (load_fire) begin
            if (row_idx == LAST_IDX) begin
              row_idx  <= '0;
              beat_idx <= '0;
              state    <= STREAM;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (beat_idx == LAST_IDX) begin
              beat_idx <= '0;
              row_idx  <= '0;
              state    <= LOAD_A;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= LOAD_A;
          row_idx  <= '0;
          beat_idx <= '0;
        end
      endcase
    end
  end

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .IDX_BITS   (IDX_BITS),
    .READ_COLUMN(1'b1)
  ) u_buf_a (
    .clk    (clk),
    .wr_en  (load_fire && (state == LOAD_A)),
    .wr_row (row_idx),
    .wr_data(load_data),
    .rd_idx (beat_idx),
    .rd_data(a_col)
  );

  operand_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .IDX_BITS   (IDX_BITS),
    .READ_COLUMN(1'b0)
  ) u_buf_b (
    .clk    (clk),
    .wr_en  (load_fire && (state == LOAD_B)),
    .wr_row (row_idx),
    .wr_data(load_data),
    .rd_idx (beat_idx),
    .rd_data(b_row)
  );

endmodule

// File: tb/tb_operand_streamer.sv
// Randomized and directed checks of operand_streamer against a matrix-level reference model.
module tb_operand_streamer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic                 clk;
  logic                 reset;
  logic                 load_valid;
  logic                 load_ready;
  logic [N-1:0][DW-1:0] load_data;
  logic                 a_input_valid;
  logic                 b_input_valid;
  logic                 input_ready;
  logic                 last;
  logic [N-1:0][DW-1:0] a_data;
  logic [N-1:0][DW-1:0] b_data;
  logic                 busy;

  int ma[N][N];
  int mb[N][N];
  int n_checks = 0;
  int n_fail   = 0;

  operand_streamer #(
    .DATA_WIDTH(DW),
    .N         (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .a_input_valid(a_input_valid),
    .b_input_valid(b_input_valid),
    .input_ready  (input_ready),
    .last         (last),
    .a_data       (a_data),
    .b_data       (b_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = N * i + j + 1;
        mb[i][j] = 17 + N * i + j;
      end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = int'($urandom_range(0, 255));
        mb[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  // Column k of A and row k of B, as the array expects them.
  function automatic logic [N-1:0][DW-1:0] a_col(input int k);
    logic [N-1:0][DW-1:0] v;
    for (int i = 0; i < N; i++) v[i] = DW'(ma[i][k]);
    return v;
  endfunction

  function automatic logic [N-1:0][DW-1:0] b_row(input int k);
    logic [N-1:0][DW-1:0] v;
    for (int j = 0; j < N; j++) v[j] = DW'(mb[k][j]);
    return v;
  endfunction

  // mode 0: no bubbles, 1: valid toggles 1,0,1,0..., 2: random bubbles
  task automatic load_pair(input int mode, output int cycles);
    int  idx;
    bit  v;
    idx    = 0;
    cycles = 0;
    while (idx < 2 * N) begin
      @(negedge clk);
      check("load_ready", 64'(load_ready), 64'(1));
      check("idle_valids", 64'({a_input_valid, b_input_valid, last}), 64'(0));
      check("idle_a_data", 64'(a_data), 64'(0));
      check("idle_b_data", 64'(b_data), 64'(0));
      check("busy_load", 64'(busy), 64'(idx != 0));
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cycles % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      load_valid = v;
      for (int j = 0; j < N; j++)
        load_data[j] = v ? DW'(idx < N ? ma[idx][j] : mb[idx - N][j]) : DW'(8'hEE);
      @(posedge clk);
      cycles++;
      if (v) idx++;
      if (cycles > 200) begin
        check("load_timeout", 64'(1), 64'(0));
        break;
      end
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: three stall cycles at beat 1
  task automatic run_stream(input int mode, input bit load_junk, input int abort_k,
                            output int cycles);
    int k;
    int stalls;
    bit rdy;
    k      = 0;
    stalls = 0;
    cycles = 0;
    while (k < N) begin
      @(negedge clk);
      if (abort_k >= 0 && k == abort_k) return;
      check("a_valid", 64'(a_input_valid), 64'(1));
      check("b_valid", 64'(b_input_valid), 64'(1));
      check("a_data", 64'(a_data), 64'(a_col(k)));
      check("b_data", 64'(b_data), 64'(b_row(k)));
      check("last", 64'(last), 64'(k == N - 1));
      check("load_ready_stream", 64'(load_ready), 64'(0));
      check("busy_stream", 64'(busy), 64'(1));
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (k == 1 && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else rdy = 1'b1;
      input_ready = rdy;
      load_valid  = load_junk;
      load_data   = '1;
      @(posedge clk);
      cycles++;
      if (rdy) k++;
      if (cycles > 200) begin
        check("stream_timeout", 64'(1), 64'(0));
        break;
      end
    end
  endtask

  initial begin
    int lc;
    int sc;
    reset       = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    input_ready = 1'b0;
    #3;
    check("rst_load_ready", 64'(load_ready), 64'(1));
    check("rst_valids", 64'({a_input_valid, b_input_valid, last}), 64'(0));
    check("rst_data", 64'({a_data, b_data}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Basic pair with exact timing, then the same pair loaded with bubbles and stalled.
    set_basic();
    load_pair(0, lc);
    check("load_cycles", 64'(lc), 64'(2 * N));
    run_stream(0, 1'b0, -1, sc);
    check("stream_cycles", 64'(sc), 64'(N));
    load_pair(1, lc);
    check("bubble_load_cycles", 64'(lc), 64'(4 * N - 1));
    run_stream(2, 1'b0, -1, sc);
    check("stall_stream_cycles", 64'(sc), 64'(N + 3));

    // Back-to-back constant pair with junk offered on the load port during streaming.
    set_const(2, 3);
    load_pair(0, lc);
    run_stream(0, 1'b1, -1, sc);
    check("junk_stream_cycles", 64'(sc), 64'(N));

    // Reset mid-stream must drop the valids without a clock edge.
    set_basic();
    load_pair(0, lc);
    run_stream(0, 1'b0, 2, sc);
    #1 reset = 1'b1;
    #1;
    check("async_valids", 64'({a_input_valid, b_input_valid, last}), 64'(0));
    check("async_data", 64'({a_data, b_data}), 64'(0));
    check("async_load_ready", 64'(load_ready), 64'(1));
    input_ready = 1'b0;
    load_valid  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    set_random();
    load_pair(0, lc);
    run_stream(0, 1'b0, -1, sc);

    // Randomized pairs: random data, load bubbles, backpressure and junk loads.
    for (int p = 0; p < 6; p++) begin
      set_random();
      load_pair(2, lc);
      run_stream(1, bit'($urandom_range(0, 1)), -1, sc);
    end

    @(negedge clk);
    load_valid  = 1'b0;
    input_ready = 1'b0;
    check("end_load_ready", 64'(load_ready), 64'(1));
    check("end_busy", 64'(busy), 64'(0));
    check("end_valids", 64'({a_input_valid, b_input_valid, last}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
